// File: rtl/mcu_int_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mcu_int_pkg
//  Brief    : Shared types and constants for the MCU interrupt controller.
//  Revision : 1.0  initial release
// ============================================================================
package mcu_int_pkg;

  localparam int NUM_SRC  = 8;

  // Fixed source assignments on the controller inputs
  localparam int INT_SYS  = 0;
  localparam int INT_SDC  = 1;
  localparam int INT_HID  = 2;
  localparam int INT_PORT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } int_state_t;

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_src_cell.sv
`default_nettype none
// ============================================================================
//  Module   : int_src_cell
//  Brief    : One interrupt source: edge/level capture, sticky pending bit,
//             lost-event flag and acknowledge pulse back to the source.
//  Revision : 1.0  initial release
// ============================================================================
module int_src_cell #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_src,
  input  logic i_ack,
  input  logic i_lost_clr,
  output logic o_pend,
  output logic o_lost,
  output logic o_src_ack
);

  logic r_prev;
  logic r_pend;
  logic r_lost;
  logic r_src_ack;

  logic w_rise;
  logic w_set;
  logic w_hit;
  logic w_lost_set;

  assign w_rise     = i_src & ~r_prev;
  assign w_set      = EDGE ? w_rise : i_src;
  // An acknowledge only counts against a bit that is actually pending
  assign w_hit      = i_ack & r_pend;
  // A fresh edge on an already pending, un-acked bit means an event merged away
  assign w_lost_set = EDGE & w_rise & r_pend & ~i_ack;

  // History of the request line; tracks it during reset so a line held high
  // across reset release does not look like a new edge
  always_ff @(posedge clk) begin
    r_prev <= i_src;
  end

  // Pending / lost / ack state; a new request beats a simultaneous ack or clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_lost    <= 1'b0;
      r_src_ack <= 1'b0;
    end else begin
      r_pend    <= w_set | (r_pend & ~w_hit);
      r_src_ack <= w_hit;
      r_lost    <= w_lost_set | (r_lost & ~i_lost_clr);
    end
  end

  assign o_pend    = r_pend;
  assign o_lost    = r_lost;
  assign o_src_ack = r_src_ack;

endmodule
`default_nettype wire

// File: rtl/mcu_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mcu_int_ctrl
//  Brief    : Interrupt controller feeding the MCU int_in/int_ack interface.
//             Masked pending requests are forwarded while ACTIVE; every ack
//             forces a quiet gap so the MCU pin always sees a fresh edge.
//  Revision : 1.0  initial release
// ============================================================================
module mcu_int_ctrl
  import mcu_int_pkg::*;
#(
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 8'b0000_0000,
  parameter int                 HOLDOFF   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] i_src_in,
  input  logic [NUM_SRC-1:0] i_mask,
  input  logic [NUM_SRC-1:0] i_int_ack,
  input  logic [NUM_SRC-1:0] i_lost_clr,
  output logic [NUM_SRC-1:0] o_int_pending,
  output logic [NUM_SRC-1:0] o_src_ack,
  output logic [NUM_SRC-1:0] o_lost,
  output logic [2:0]         o_active_src,
  output logic               o_int_any
);

  localparam int                  c_CNT_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [c_CNT_W-1:0] c_GAP_LOAD =
    c_CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  int_state_t         r_state;
  int_state_t         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_req;
  logic               w_any;
  logic               w_ack_hit;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    int_src_cell #(
      .EDGE (EDGE_MASK[gi])
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .i_src      (i_src_in[gi]),
      .i_ack      (i_int_ack[gi]),
      .i_lost_clr (i_lost_clr[gi]),
      .o_pend     (w_pend[gi]),
      .o_lost     (o_lost[gi]),
      .o_src_ack  (o_src_ack[gi])
    );
  end

  assign w_req     = w_pend & i_mask;
  assign w_any     = |w_req;
  assign w_ack_hit = |(i_int_ack & w_pend);

  // State and gap counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: an ack ends the ACTIVE phase, masking everything away too
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (w_ack_hit) begin
          if (HOLDOFF > 0) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = c_GAP_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (!w_any) begin
          w_state_nxt = IDLE;
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: the MCU only sees requests while ACTIVE; status is state-independent
  always_comb begin
    o_int_pending = '0;
    if (r_state == ACTIVE) o_int_pending = w_req;
    o_active_src  = lowest_idx(w_req);
    o_int_any     = w_any;
  end

endmodule
`default_nettype wire

// File: tb/tb_mcu_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcu_int_ctrl
//  Brief    : Self-checking bench for mcu_int_ctrl: directed vector table,
//             reset corner sequences and random traffic against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mcu_int_ctrl;
  import mcu_int_pkg::*;

  localparam logic [7:0] c_EDGE    = 8'hF6;  // sources 1,2,4..7 edge; 0,3 level
  localparam int         c_HOLDOFF = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src_in, mask, int_ack, lost_clr;
  logic [7:0] int_pending, src_ack, lost;
  logic [2:0] active_src;
  logic       int_any;

  int n_checks = 0;
  int n_errors = 0;

  mcu_int_ctrl #(
    .EDGE_MASK (c_EDGE),
    .HOLDOFF   (c_HOLDOFF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_src_in      (src_in),
    .i_mask        (mask),
    .i_int_ack     (int_ack),
    .i_lost_clr    (lost_clr),
    .o_int_pending (int_pending),
    .o_src_ack     (src_ack),
    .o_lost        (lost),
    .o_active_src  (active_src),
    .o_int_any     (int_any)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending set, lost set, ack pulses, and a forwarding
  // window described as "live" plus a number of remaining blanked cycles.
  logic [7:0] m_pend = '0, m_lost = '0, m_prev = '0, m_sack = '0;
  logic       m_live = 1'b0;
  int         m_quiet = 0;

  task automatic model_step();
    logic [7:0] events, rises, hits, req_old;
    if (reset) begin
      m_pend = '0; m_lost = '0; m_sack = '0; m_prev = src_in;
      m_live = 1'b0; m_quiet = 0;
      return;
    end
    rises   = src_in & ~m_prev;
    events  = (c_EDGE & rises) | (~c_EDGE & src_in);
    hits    = int_ack & m_pend;
    req_old = m_pend & mask;
    if (m_quiet > 0)      m_quiet = m_quiet - 1;
    else if (!m_live)     m_live = (req_old != 0);
    else if (hits != 0) begin
      m_live  = 1'b0;
      m_quiet = c_HOLDOFF;
    end
    else if (req_old == 0) m_live = 1'b0;
    m_lost = (c_EDGE & rises & m_pend & ~int_ack) | (m_lost & ~lost_clr);
    m_pend = events | (m_pend & ~hits);
    m_sack = hits;
    m_prev = src_in;
  endtask

  function automatic logic [2:0] model_low(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] s, input logic [7:0] m,
                      input logic [7:0] a, input logic [7:0] c);
    @(negedge clk);
    reset = r; src_in = s; mask = m; int_ack = a; lost_clr = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_pnd, input logic [7:0] e_sack,
                         input logic [7:0] e_lost, input logic [2:0] e_act, input logic e_any);
    chk({tag, ".int_pending"}, int_pending, e_pnd);
    chk({tag, ".src_ack"}, src_ack, e_sack);
    chk({tag, ".lost"}, lost, e_lost);
    chk({tag, ".active_src"}, {5'd0, active_src}, {5'd0, e_act});
    chk({tag, ".int_any"}, {7'd0, int_any}, {7'd0, e_any});
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] req;
    req = m_pend & mask;
    chk_all(tag, m_live ? req : 8'h00, m_sack, m_lost, model_low(req), |req);
  endtask

  typedef struct {
    logic [7:0] src, msk, ack, clr;
    logic [7:0] e_pnd, e_sack, e_lost;
    logic [2:0] e_act;
    logic       e_any;
  } vec_t;

  vec_t tbl[40];
  logic [7:0] r_msk;

  initial begin
    // src  mask  ack   clr  | pending sack lost act any
    tbl[0]  = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1};
    tbl[2]  = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 3'd1, 1'b1};
    tbl[3]  = '{8'h00, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 3'd0, 1'b0};
    for (int i = 4; i <= 8; i++)
      tbl[i] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[9]  = '{8'h08, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd3, 1'b1};
    tbl[10] = '{8'h08, 8'hFF, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 3'd3, 1'b1};
    tbl[11] = '{8'h08, 8'hFF, 8'h08, 8'h00, 8'h00, 8'h08, 8'h00, 3'd3, 1'b1};
    for (int i = 12; i <= 15; i++)
      tbl[i] = '{8'h08, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd3, 1'b1};
    tbl[16] = '{8'h08, 8'hFF, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 3'd3, 1'b1};
    tbl[17] = '{8'h00, 8'hFF, 8'h08, 8'h00, 8'h00, 8'h08, 8'h00, 3'd0, 1'b0};
    for (int i = 18; i <= 21; i++)
      tbl[i] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[22] = '{8'h06, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1};
    tbl[23] = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 3'd1, 1'b1};
    tbl[24] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[25] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 3'd1, 1'b1};
    tbl[26] = '{8'h04, 8'hFF, 8'h00, 8'h00, 8'h06, 8'h00, 8'h04, 3'd1, 1'b1};
    tbl[27] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h06, 8'h00, 8'h04, 3'd1, 1'b1};
    tbl[28] = '{8'h04, 8'hFF, 8'h04, 8'h00, 8'h00, 8'h04, 8'h04, 3'd1, 1'b1};
    tbl[29] = '{8'h00, 8'hFF, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1};
    for (int i = 30; i <= 32; i++)
      tbl[i] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1};
    tbl[33] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 3'd1, 1'b1};
    tbl[34] = '{8'h00, 8'hFF, 8'h80, 8'h00, 8'h06, 8'h00, 8'h00, 3'd1, 1'b1};
    tbl[35] = '{8'h00, 8'hFF, 8'h06, 8'h00, 8'h00, 8'h06, 8'h00, 3'd0, 1'b0};
    for (int i = 36; i <= 39; i++)
      tbl[i] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};

    reset = 1'b1; src_in = '0; mask = '0; int_ack = '0; lost_clr = '0;

    // Reset with the SDC edge source held high; nothing may appear on release
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h02, 8'hFF, 8'h00, 8'h00);
    chk_all("reset", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick(1'b0, 8'h02, 8'hFF, 8'h00, 8'h00);
    chk_all("held_edge", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick(1'b0, 8'h02, 8'hFF, 8'h00, 8'h00);
    chk_all("held_edge2", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);

    // Directed vectors
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, tbl[i].src, tbl[i].msk, tbl[i].ack, tbl[i].clr);
      chk_all($sformatf("tbl[%0d]", i), tbl[i].e_pnd, tbl[i].e_sack,
              tbl[i].e_lost, tbl[i].e_act, tbl[i].e_any);
    end

    // Reset asserted in the middle of a gap with a request still pending
    tick(1'b0, 8'h06, 8'hFF, 8'h00, 8'h00);
    tick(1'b0, 8'h00, 8'hFF, 8'h00, 8'h00);
    chk_all("gap_pre", 8'h06, 8'h00, 8'h00, 3'd1, 1'b1);
    tick(1'b0, 8'h00, 8'hFF, 8'h02, 8'h00);
    chk_all("gap_ack", 8'h00, 8'h02, 8'h00, 3'd2, 1'b1);
    tick(1'b0, 8'h00, 8'hFF, 8'h00, 8'h00);
    chk_all("gap_mid", 8'h00, 8'h00, 8'h00, 3'd2, 1'b1);
    tick(1'b1, 8'h00, 8'hFF, 8'h00, 8'h00);
    chk_all("gap_reset", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick(1'b0, 8'h00, 8'hFF, 8'h00, 8'h00);
    chk_all("gap_after", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);

    // Random traffic against the model
    r_msk = 8'hFF;
    for (int i = 0; i < 800; i++) begin
      logic       r;
      logic [7:0] s, a, c;
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) r_msk = 8'($urandom);
      s = 8'($urandom) & 8'($urandom) & 8'($urandom);
      a = ($urandom_range(0, 3) == 0) ? (8'($urandom) & (m_pend | 8'($urandom))) : 8'h00;
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      tick(r, s, r_msk, a, c);
      chk_model($sformatf("rnd[%0d]", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcu_int_ctrl.md
# mcu_int_ctrl

Interrupt controller between the core's interrupt sources (system control, SD card, HID, serial port, …) and the 8-bit `int_in`/`int_ack` interface of the MCU system-control block. It latches level- and edge-type requests into sticky pending bits and applies a per-source mask. It clears pending bits on MCU acknowledge and returns per-source ack pulses to the sources. After every acknowledge it enforces a minimum de-assert gap, so the MCU's edge-sensitive interrupt pin always sees a fresh falling edge of `int_out_n`.

## Interface
Parameters:
- `EDGE_MASK`, default 8'b0000_0000: bit i = 1 makes source i rising-edge triggered; 0 makes it level triggered.
- `HOLDOFF`, default 16: length of the gap state in clock cycles after an acknowledge; 0 disables the gap.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `src_in`  in  8  interrupt requests from the sources, same clock domain.
- `mask`  in  8  per-source enable; 1 = forwarded to the MCU.
- `int_ack`  in  8  one-cycle acknowledge vector from the system-control block.
- `lost_clr`  in  8  one-cycle clear of the sticky lost flags.
- `int_pending`  out  8  drives the system-control block's `int_in`.
- `src_ack`  out  8  one-cycle pulse back to source i when its pending bit is acknowledged.
- `lost`  out  8  sticky flag per source: an edge event arrived while the source was already pending.
- `active_src`  out  3  index of the lowest-numbered masked pending source; 0 when none.
- `int_any`  out  1  OR of `pend & mask`.

## Operation
- The per-source register `pend[i]` is set as follows:
  - Edge source: set on `src_in[i] & ~prev[i]`.
  - Level source: set whenever `src_in[i]` = 1.
- `int_ack[i]` & `pend[i]` clears `pend[i]` and registers `src_ack[i]` = 1 for exactly the next cycle.
- If set and ack hit the same bit in the same cycle, set wins and `src_ack[i]` still pulses. No event is dropped.
- Ack bits whose pend bit is 0 are ignored: no `src_ack`, no state change.
- `lost[i]` is set when an edge event arrives while `pend[i]` = 1 and is not acknowledged in the same cycle. `lost_clr[i]` clears it; if set and clear coincide, set wins.
- Masked sources keep accumulating `pend`. Unmasking forwards them.
- FSM states are IDLE, ACTIVE and GAP:
  - IDLE: if (`pend` & `mask`) ≠ 0, go to ACTIVE.
  - ACTIVE: `int_pending` = `pend` & `mask`.
    - If `int_ack` & `pend` ≠ 0 and HOLDOFF > 0, go to GAP and load the counter with HOLDOFF−1.
    - If `int_ack` & `pend` ≠ 0 and HOLDOFF = 0, go to IDLE.
    - If (`pend` & `mask`) = 0 through masking, go to IDLE.
  - GAP: `int_pending` = 0 and the counter decrements. At counter = 0, go to IDLE.
- `int_pending` = 0 in IDLE and GAP.
- `active_src` and `int_any` are combinational from `pend` & `mask` and do not depend on FSM state.

## Timing
- Reset values:
  - `pend` = 0, `lost` = 0, `src_ack` = 0, FSM = IDLE, counter = 0.
  - Outputs `int_pending` = 0, `active_src` = 0, `int_any` = 0.
  - `prev` loads `src_in` during reset, so a source held high produces no edge at reset release.
- Latency from an IDLE start:
  - `src_in` sampled high at edge N → `pend` set after N.
  - FSM reaches ACTIVE after N+1, so `int_pending` is valid 2 edges after sampling.
- In ACTIVE, newly set pend bits appear on `int_pending` 1 edge after sampling.
- After an ack at edge M:
  - `int_pending` = 0 from M+1 through M+HOLDOFF.
  - ACTIVE is possible again at M+HOLDOFF+2 if work remains.
- `src_ack` is valid in cycle M+1 only.
- Reset during GAP or ACTIVE aborts immediately to the reset values.

## Structure
- Package `mcu_int_pkg` holds:
  - state enum `int_state_t` (IDLE, ACTIVE, GAP);
  - `NUM_SRC` = 8;
  - source index constants `INT_SYS` = 0, `INT_SDC` = 1, `INT_HID` = 2, `INT_PORT` = 3.
- Sub-module `int_src_cell` is instantiated 8 times. Each holds `prev`, `pend`, `lost` and `src_ack` for one bit, with parameter EDGE.
- The FSM, counter and priority encoder live in the top module.

## Test plan
- Edge source 1, HOLDOFF=4, mask=FF: pulse `src_in[1]` → `int_pending`=02 two edges later; `int_ack`=02 → `src_ack`=02 for one cycle, `int_pending`=00 for 4 cycles, FSM back in IDLE.
- Level source 3 held high, HOLDOFF=4: ack → `int_pending` drops for 4 cycles, then re-asserts 08.
- Masking: `pend`=06 with mask=02 → `int_pending`=02 and `active_src`=1. Then set mask=00 → FSM goes to IDLE and `int_pending`=00. Restore mask=FF → `int_pending`=06.
- Overlap on edge source 2: second edge while pending → `lost`=04. An edge coinciding with `int_ack`=04 → pend stays 1, `src_ack` pulses, `lost` unchanged. Then `lost_clr`=04 → `lost`=00.
- Reset: hold `src_in`[1]=1 (edge source) through reset → no pend after release. Assert reset mid-GAP → all outputs 0 next cycle.
- Bogus ack: `int_ack`=80 with `pend`=02 → no `src_ack`, FSM stays in ACTIVE, `int_pending`=02.
